// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction memory.
// Holds the loader state encoding and the default memory geometry.
package inst_mem_loader_pkg;

    localparam int LDR_ADDR_W = 12;
    localparam int LDR_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } ldr_state_t;

endpackage

// File: rtl/ldr_write_stage.sv
// Registered instruction-memory write port of the loader.
// Each accepted word becomes exactly one write on the following cycle.
module ldr_write_stage #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= wr_en;
            if (wr_en) begin
                mem_addr  <= wr_addr;
                mem_wdata <= wr_data;
            end
        end
    end

endmodule

// File: rtl/inst_mem_loader.sv
// Streams instruction words into instruction memory from a base address,
// keeping the fetch stage held in reset until a load completes cleanly.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int ADDR_W = LDR_ADDR_W,
    parameter int DATA_W = LDR_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   word_count,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] checksum,
    output logic              cpu_hold
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    ldr_state_t        state, state_n;
    logic [ADDR_W-1:0] addr, pend_base, go_base;
    logic [ADDR_W:0]   remaining, pend_count, go_count;
    logic              pend_valid, go, xfer;

    assign in_ready = (state == LOAD);
    assign busy     = (state == LOAD);
    assign done     = (state == DONE);
    assign error    = (state == ERR);
    assign xfer     = in_valid && in_ready;

    // A start seen during DONE is parked and replayed in the following IDLE cycle.
    always_comb begin
        go       = 1'b0;
        go_base  = base_addr;
        go_count = word_count;
        if (state == IDLE && pend_valid) begin
            go       = 1'b1;
            go_base  = pend_base;
            go_count = pend_count;
        end else if ((state == IDLE || state == ERR) && start) begin
            go = 1'b1;
        end

        state_n = state;
        case (state)
            IDLE, ERR: if (go) state_n = (go_count != '0) ? LOAD : DONE;
            LOAD: begin
                if (xfer) begin
                    if (remaining == CNT_ONE)  state_n = DONE;
                    else if (addr == ADDR_MAX) state_n = ERR;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // The address saturates at the top so an overflowing load never touches word 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            remaining  <= '0;
            checksum   <= '0;
            cpu_hold   <= 1'b1;
            pend_valid <= 1'b0;
            pend_base  <= '0;
            pend_count <= '0;
        end else begin
            if (go) begin
                addr      <= go_base;
                remaining <= go_count;
                checksum  <= '0;
            end else if (xfer) begin
                checksum  <= checksum + in_data;
                remaining <= remaining - CNT_ONE;
                if (addr != ADDR_MAX) addr <= addr + ADDR_ONE;
            end

            if (state_n == LOAD || state_n == ERR) cpu_hold <= 1'b1;
            else if (state_n == DONE)              cpu_hold <= 1'b0;

            if (state == DONE && start) begin
                pend_valid <= 1'b1;
                pend_base  <= base_addr;
                pend_count <= word_count;
            end else if (state == IDLE) begin
                pend_valid <= 1'b0;
            end
        end
    end

    ldr_write_stage #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_write_stage (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (xfer),
        .wr_addr  (addr),
        .wr_data  (in_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata)
    );

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: directed loads from the test plan
// followed by randomized loads checked against a per-load expectation model.
module tb_inst_mem_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] word_count;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] checksum;
    logic        cpu_hold;

    int vectors;
    int miscompares;

    logic [15:0] fixed_words[$];
    bit          valid_pat[$];

    inst_mem_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .word_count(word_count),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum),
        .cpu_hold  (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete load: the model knows how many words fit below the top of
    // memory, where each must land, and what the running sum must come to.
    task automatic run_load(input logic [11:0] base, input logic [12:0] cnt, input int vprob);
        int          room, n_exp, acc;
        bit          ovf, prev_x, finished, v;
        logic [15:0] sum, prev_d, d;
        logic [11:0] exp_a;
        room   = 4096 - int'(base);
        ovf    = int'(cnt) > room;
        n_exp  = ovf ? room : int'(cnt);
        sum    = '0;
        acc    = 0;
        prev_x = 1'b0;
        prev_d = '0;
        finished = 1'b0;

        start = 1'b1; base_addr = base; word_count = cnt;
        @(posedge clk); @(negedge clk);
        start = 1'b0;

        if (cnt == 0) begin
            chk("zero_done",     32'(done),     32'd1);
            chk("zero_we",       32'(mem_we),   32'd0);
            chk("zero_checksum", 32'(checksum), 32'd0);
            chk("zero_hold",     32'(cpu_hold), 32'd0);
            @(negedge clk);
            chk("zero_done_end", 32'(done),     32'd0);
            return;
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            chk("we", 32'(mem_we), 32'(prev_x));
            if (prev_x) begin
                exp_a = base + 12'(acc - 1);
                chk("addr",  32'(mem_addr),  32'(exp_a));
                chk("wdata", 32'(mem_wdata), 32'(prev_d));
            end
            if (acc == n_exp) begin
                chk("end_done",  32'(done),     32'(!ovf));
                chk("end_error", 32'(error),    32'(ovf));
                chk("end_hold",  32'(cpu_hold), 32'(ovf));
                chk("end_ready", 32'(in_ready), 32'd0);
                chk("end_busy",  32'(busy),     32'd0);
                finished = 1'b1;
                break;
            end
            chk("load_ready", 32'(in_ready), 32'd1);
            chk("load_error", 32'(error),    32'd0);
            chk("load_hold",  32'(cpu_hold), 32'd1);

            if (valid_pat.size() != 0) v = valid_pat.pop_front();
            else                       v = ($urandom_range(0, 99) < vprob);
            if (v && fixed_words.size() != 0) d = fixed_words.pop_front();
            else                               d = 16'($urandom);
            in_valid = v;
            in_data  = d;
            prev_x   = v;
            prev_d   = d;
            if (v) begin
                acc++;
                sum = sum + d;
            end
            @(posedge clk); @(negedge clk);
            in_valid = 1'b0;
        end
        if (!finished) chk("timeout", 32'd0, 32'd1);
        chk("checksum", 32'(checksum), 32'(sum));

        @(negedge clk);
        chk("after_we",    32'(mem_we),   32'd0);
        chk("after_done",  32'(done),     32'd0);
        chk("after_error", 32'(error),    32'(ovf));
        chk("after_hold",  32'(cpu_hold), 32'(ovf));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        start       = 1'b0;
        base_addr   = '0;
        word_count  = '0;
        in_valid    = 1'b0;
        in_data     = '0;

        repeat (2) @(negedge clk);
        chk("rst_hold",     32'(cpu_hold), 32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_we",       32'(mem_we),   32'd0);
        chk("rst_ready",    32'(in_ready), 32'd0);
        chk("rst_checksum", 32'(checksum), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        fixed_words = '{16'h1111, 16'h2222, 16'h3333};
        valid_pat   = '{1'b1, 1'b1, 1'b1};
        run_load(12'h000, 13'd3, 100);
        chk("sum_6666", 32'(checksum), 32'h6666);

        valid_pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        run_load(12'h010, 13'd2, 100);

        run_load(12'hFFE, 13'd4, 100);
        run_load(12'h100, 13'd5, 70);

        run_load(12'h000, 13'd0, 100);

        start = 1'b1; base_addr = 12'h200; word_count = 13'd3;
        @(posedge clk); @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_we",       32'(mem_we),    32'd0);
        chk("mid_rst_addr",     32'(mem_addr),  32'd0);
        chk("mid_rst_wdata",    32'(mem_wdata), 32'd0);
        chk("mid_rst_hold",     32'(cpu_hold),  32'd1);
        chk("mid_rst_busy",     32'(busy),      32'd0);
        chk("mid_rst_ready",    32'(in_ready),  32'd0);
        chk("mid_rst_checksum", 32'(checksum),  32'd0);
        chk("mid_rst_done",     32'(done),      32'd0);
        chk("mid_rst_error",    32'(error),     32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        fixed_words = '{16'hFFFF, 16'h0002};
        run_load(12'h020, 13'd2, 100);
        chk("sum_carry", 32'(checksum), 32'h0001);

        for (int i = 0; i < 20; i++) begin
            logic [11:0] b;
            if ($urandom_range(0, 3) == 0) b = 12'(4090 + $urandom_range(0, 5));
            else                           b = 12'($urandom_range(0, 4095));
            run_load(b, 13'($urandom_range(0, 10)), int'($urandom_range(40, 100)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Write-side companion to the fetch stage.
- Accepts a stream of 16-bit instruction words over a valid/ready handshake and writes them sequentially into instruction memory from a programmable base address.
- Holds the fetch stage in reset until loading completes: cpu_hold drives the fetch reset, so PC restarts at 0 after a load.
- Keeps a running 16-bit checksum so the host can confirm the image.

Parameters:
- ADDR_W, 12, instruction-memory address width; depth is 2^ADDR_W words.
- DATA_W, 16, instruction word width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE, DONE or ERR.
- base_addr  in  ADDR_W  first write address; latched on start.
- word_count  in  ADDR_W+1  number of words to load; latched on start.
- in_valid  in  1  in_data is valid.
- in_data  in  DATA_W  instruction word.
- in_ready  out  1  loader accepts a word this cycle.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse when a load completes.
- error  out  1  sticky flag: the load ran past the top of memory.
- checksum  out  DATA_W  modulo-2^16 sum of the words accepted in the current load.
- cpu_hold  out  1  drives the fetch-stage reset; 1 = processor held.

Behaviour:
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, checksum=0, cpu_hold=1. The processor stays held until the first successful load.
- States: IDLE, LOAD, DONE, ERR.
- IDLE:
  - start=1 with word_count≠0: latch addr=base_addr and remaining=word_count, clear checksum and error, assert cpu_hold, go to LOAD.
  - start=1 with word_count=0: go to DONE with no writes.
- LOAD:
  - busy=1; in_ready=1 combinationally (no backpressure once in LOAD).
  - A transfer is in_valid & in_ready. On a transfer, the next cycle drives mem_we=1, mem_addr=addr, mem_wdata=in_data (write latency 1 cycle). In the same cycle addr++, remaining--, checksum += in_data.
  - No transfer in a cycle: mem_we=0 in the next cycle.
- Completion: the transfer that makes remaining=0 moves the state to DONE. That word's write and the done pulse occur in the same cycle.
- Overflow:
  - Condition: a transfer at addr=2^ADDR_W−1 with remaining>1.
  - That word is written, then the state moves to ERR.
  - Address never wraps to 0 and nothing is written at 0.
- DONE: done=1 for exactly one cycle, busy=0, cpu_hold=0, then IDLE. checksum holds its value until the next start.
- ERR: error=1 (sticky), busy=0, cpu_hold=1, in_ready=0. Leaves ERR only on start, which begins a new load, or on reset.
- start while in LOAD is ignored.
- start in the same cycle as DONE is honoured in the following IDLE cycle.
- cpu_hold after a completed load stays 0. It rises again only on start, reset or error.
- Reset mid-load: abort immediately, mem_we=0, cpu_hold=1; any partially written words remain in memory.
- Checksum: plain addition, carry discarded, DATA_W wide.
- Exactly one mem write per accepted word; never more than one write per cycle.

Decomposition:
- Shared package: state encoding (IDLE=2'd0, LOAD=2'd1, DONE=2'd2, ERR=2'd3) and the default ADDR_W/DATA_W constants, also used by the instruction memory.
- One sub-module, ldr_write_stage: the registered mem_we/mem_addr/mem_wdata output stage. The controller FSM, counters and checksum stay in the top module.

Test Plan:
- Reset → cpu_hold=1, busy=0, mem_we=0, in_ready=0, checksum=0.
- base_addr=0, word_count=3, words 0x1111/0x2222/0x3333 with continuous valid → writes at addr 0,1,2 one cycle after each accept; done pulse in the cycle of the last write; checksum=0x6666; cpu_hold=0 afterwards.
- base_addr=0x010, word_count=2, in_valid toggled 1,0,0,1 → exactly 2 writes at 0x010 and 0x011; mem_we=0 in the idle gaps; done after the second write.
- base_addr=0xFFE, word_count=4 → writes at 0xFFE and 0xFFF, then error=1 and cpu_hold=1; no write at 0x000; next start with a valid load clears error.
- start with word_count=0 → done pulses one cycle later with no mem_we; checksum=0.
- Assert reset after 1 of 3 words accepted → all outputs at reset values next cycle, cpu_hold=1; a following load of 0xFFFF, 0x0002 yields checksum=0x0001 (carry dropped).
